// File: rtl/parking_pkg.sv
// Shared types for the parking entry lane: barrier states, sensor codes and default capacity.
package parking_pkg;

    typedef enum logic [1:0] {
        CERRADA = 2'b00,
        ABIERTA = 2'b01,
        CIERRE  = 2'b10
    } estado_barrera_t;

    // Sensor codes as produced by fsm_estacionamiento.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        B_ON  = 2'b01,
        A_ON  = 2'b10,
        AB_ON = 2'b11
    } sensor_t;

    localparam int unsigned CAPACIDAD_DEF = 8;

endpackage

// File: rtl/parking_contador.sv
// Saturating occupancy up/down counter with full/empty decode and one-cycle misuse flags.
module parking_contador
    import parking_pkg::*;
#(
    parameter  int unsigned CAPACIDAD = CAPACIDAD_DEF,
    localparam int unsigned W         = $clog2(CAPACIDAD + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         entrada,
    input  logic         salida,
    output logic [W-1:0] ocupacion,
    output logic         lleno,
    output logic         vacio,
    output logic         error_ovf,
    output logic         error_udf
);

    localparam logic [W-1:0] MAXV = W'(CAPACIDAD);

    assign lleno = (ocupacion == MAXV);
    assign vacio = (ocupacion == '0);

    // Simultaneous entrada and salida cancel out, even at the limits.
    always_ff @(posedge clk) begin
        if (reset) begin
            ocupacion <= '0;
            error_ovf <= 1'b0;
            error_udf <= 1'b0;
        end else begin
            error_ovf <= 1'b0;
            error_udf <= 1'b0;
            case ({entrada, salida})
                2'b10: begin
                    if (lleno) error_ovf <= 1'b1;
                    else       ocupacion <= ocupacion + 1'b1;
                end
                2'b01: begin
                    if (vacio) error_udf <= 1'b1;
                    else       ocupacion <= ocupacion - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/parking_ocupacion_ctrl.sv
// Entry-lane controller: occupancy tracking plus barrier open/hold/timeout sequencing.
// Optional PARKING_TOTAL_EN adds a saturating lifetime counter of counted entries.
module parking_ocupacion_ctrl
    import parking_pkg::*;
#(
    parameter  int unsigned CAPACIDAD      = CAPACIDAD_DEF,
    parameter  int unsigned TIMEOUT_CICLOS = 100,
    parameter  int unsigned HOLD_CICLOS    = 10,
    localparam int unsigned W              = $clog2(CAPACIDAD + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         entrada,
    input  logic         salida,
    input  logic         solicitud,
    output logic         barrera_abrir,
    output logic [W-1:0] ocupacion,
    output logic         lleno,
    output logic         vacio,
    output logic         rechazo,
`ifdef PARKING_TOTAL_EN
    output logic [15:0]  total_entradas,
`endif
    output logic         error_ovf,
    output logic         error_udf
);

    localparam int unsigned TMAX = (TIMEOUT_CICLOS > HOLD_CICLOS) ? TIMEOUT_CICLOS : HOLD_CICLOS;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    estado_barrera_t estado, estado_next;
    logic [TW-1:0]   timer, timer_next;
    logic            rechazo_next;

    parking_contador #(
        .CAPACIDAD (CAPACIDAD)
    ) u_contador (
        .clk       (clk),
        .reset     (reset),
        .entrada   (entrada),
        .salida    (salida),
        .ocupacion (ocupacion),
        .lleno     (lleno),
        .vacio     (vacio),
        .error_ovf (error_ovf),
        .error_udf (error_udf)
    );

    // lleno is the registered flag, so a request sampled with the filling entrada is still granted.
    always_comb begin
        estado_next  = estado;
        timer_next   = timer;
        rechazo_next = 1'b0;
        case (estado)
            CERRADA: begin
                if (solicitud) begin
                    if (lleno) begin
                        rechazo_next = 1'b1;
                    end else begin
                        estado_next = ABIERTA;
                        timer_next  = TW'(TIMEOUT_CICLOS - 1);
                    end
                end
            end
            ABIERTA: begin
                if (entrada) begin
                    estado_next = CIERRE;
                    timer_next  = TW'(HOLD_CICLOS - 1);
                end else if (timer == '0) begin
                    estado_next = CERRADA;
                end else begin
                    timer_next = timer - 1'b1;
                end
            end
            CIERRE: begin
                if (timer == '0) estado_next = CERRADA;
                else             timer_next  = timer - 1'b1;
            end
            default: begin
                estado_next = CERRADA;
                timer_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado        <= CERRADA;
            timer         <= '0;
            barrera_abrir <= 1'b0;
            rechazo       <= 1'b0;
        end else begin
            estado        <= estado_next;
            timer         <= timer_next;
            barrera_abrir <= (estado_next != CERRADA);
            rechazo       <= rechazo_next;
        end
    end

`ifdef PARKING_TOTAL_EN
    // Counts every entrada that the occupancy counter accepts; never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            total_entradas <= '0;
        end else if (entrada && (salida || !lleno) && (total_entradas != 16'hFFFF)) begin
            total_entradas <= total_entradas + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_parking_ocupacion_ctrl.sv
// Self-checking bench for parking_ocupacion_ctrl against a deadline-based behavioural model.
module tb_parking_ocupacion_ctrl;

    localparam int unsigned CAP  = 8;
    localparam int unsigned TOUT = 100;
    localparam int unsigned HOLD = 10;
    localparam int unsigned W    = $clog2(CAP + 1);

    logic         clk = 1'b0;
    logic         reset = 1'b0, entrada = 1'b0, salida = 1'b0, solicitud = 1'b0;
    logic         barrera_abrir, lleno, vacio, rechazo, error_ovf, error_udf;
    logic [W-1:0] ocupacion;
`ifdef PARKING_TOTAL_EN
    logic [15:0]  total_entradas;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: occupancy as an integer, barrier as an absolute closing deadline.
    int cyc = 0;
    int m_occ = 0;
    bit m_open = 0;
    bit m_passed = 0;
    int m_deadline = 0;
    bit m_rech = 0, m_ovf = 0, m_udf = 0;
    int m_total = 0;

    parking_ocupacion_ctrl #(
        .CAPACIDAD      (CAP),
        .TIMEOUT_CICLOS (TOUT),
        .HOLD_CICLOS    (HOLD)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .entrada        (entrada),
        .salida         (salida),
        .solicitud      (solicitud),
        .barrera_abrir  (barrera_abrir),
        .ocupacion      (ocupacion),
        .lleno          (lleno),
        .vacio          (vacio),
        .rechazo        (rechazo),
`ifdef PARKING_TOTAL_EN
        .total_entradas (total_entradas),
`endif
        .error_ovf      (error_ovf),
        .error_udf      (error_udf)
    );

    always #5 clk = ~clk;

    task automatic model_step(input bit r, input bit s, input bit en, input bit sa);
        cyc++;
        m_rech = 0; m_ovf = 0; m_udf = 0;
        if (r) begin
            m_occ = 0; m_open = 0; m_passed = 0; m_total = 0;
            return;
        end
        if (!m_open) begin
            if (s) begin
                if (m_occ == CAP) m_rech = 1;
                else begin m_open = 1; m_passed = 0; m_deadline = cyc + TOUT; end
            end
        end else if (!m_passed && en) begin
            m_passed = 1;
            m_deadline = cyc + HOLD;
        end else if (cyc >= m_deadline) begin
            m_open = 0;
        end
        if (en && (sa || m_occ < CAP) && m_total < 65535) m_total++;
        if (en && !sa) begin
            if (m_occ == CAP) m_ovf = 1; else m_occ++;
        end else if (sa && !en) begin
            if (m_occ == 0) m_udf = 1; else m_occ--;
        end
    endtask

    task automatic cycle(input bit r, input bit s, input bit en, input bit sa);
        @(negedge clk);
        reset = r; solicitud = s; entrada = en; salida = sa;
        @(posedge clk);
        model_step(r, s, en, sa);
        #1;
    endtask

    task automatic test_reset;
        cycle(1, 0, 0, 0);
        n_cmp++;
        if ({barrera_abrir, ocupacion, lleno, vacio, rechazo, error_ovf, error_udf} !== {1'b0, W'(0), 1'b0, 1'b1, 3'b000}) begin
            n_bad++;
            $display("FAIL reset: got bar=%b occ=%0d ll=%b va=%b rech=%b ovf=%b udf=%b, expected 0 0 0 1 0 0 0",
                     barrera_abrir, ocupacion, lleno, vacio, rechazo, error_ovf, error_udf);
        end
`ifdef PARKING_TOTAL_EN
        n_cmp++;
        if (total_entradas !== 16'd0) begin
            n_bad++; $display("FAIL reset_total: got %0d expected 0", total_entradas);
        end
`endif
    endtask

    task automatic test_entrada_seq;
        cycle(1, 0, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            cycle(0, 0, 1, 0);
            n_cmp++;
            if (ocupacion !== W'(i) || vacio !== 1'b0) begin
                n_bad++; $display("FAIL entrada_seq[%0d]: got occ=%0d vacio=%b expected occ=%0d vacio=0", i, ocupacion, vacio, i);
            end
            cycle(0, 0, 0, 0);
        end
    endtask

    task automatic test_fill_ovf;
        cycle(1, 0, 0, 0);
        for (int i = 0; i < CAP; i++) cycle(0, 0, 1, 0);
        n_cmp++;
        if (lleno !== 1'b1 || ocupacion !== W'(CAP)) begin
            n_bad++; $display("FAIL fill: got lleno=%b occ=%0d expected 1 %0d", lleno, ocupacion, CAP);
        end
        cycle(0, 0, 1, 0);
        n_cmp++;
        if (error_ovf !== 1'b1 || ocupacion !== W'(CAP)) begin
            n_bad++; $display("FAIL ovf: got ovf=%b occ=%0d expected 1 %0d", error_ovf, ocupacion, CAP);
        end
        cycle(0, 0, 0, 0);
        n_cmp++;
        if (error_ovf !== 1'b0) begin
            n_bad++; $display("FAIL ovf_pulse: got ovf=%b expected 0", error_ovf);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0, 0);
            n_cmp++;
            if (rechazo !== 1'b1 || barrera_abrir !== 1'b0) begin
                n_bad++; $display("FAIL rechazo[%0d]: got rech=%b bar=%b expected 1 0", i, rechazo, barrera_abrir);
            end
        end
        cycle(0, 0, 0, 0);
        n_cmp++;
        if (rechazo !== 1'b0) begin
            n_bad++; $display("FAIL rechazo_end: got %b expected 0", rechazo);
        end
    endtask

    task automatic test_udf_simul;
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 1);
        n_cmp++;
        if (error_udf !== 1'b1 || ocupacion !== W'(0)) begin
            n_bad++; $display("FAIL udf: got udf=%b occ=%0d expected 1 0", error_udf, ocupacion);
        end
        cycle(0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 1, 1);
            n_cmp++;
            if (ocupacion !== W'(k * 4) || error_ovf !== 1'b0 || error_udf !== 1'b0) begin
                n_bad++; $display("FAIL simul[%0d]: got occ=%0d ovf=%b udf=%b expected %0d 0 0",
                                  k, ocupacion, error_ovf, error_udf, k * 4);
            end
            if (k < 2) for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0);
        end
    endtask

    task automatic test_timeout;
        int open_cnt = 0;
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        if (barrera_abrir === 1'b1) open_cnt++;
        for (int i = 0; i < TOUT + 20; i++) begin
            cycle(0, 0, 0, 0);
            if (barrera_abrir === 1'b1) open_cnt++;
        end
        n_cmp++;
        if (open_cnt != TOUT || barrera_abrir !== 1'b0) begin
            n_bad++; $display("FAIL timeout: open %0d cycles, bar=%b; expected %0d cycles, bar=0", open_cnt, barrera_abrir, TOUT);
        end
    endtask

    task automatic run_pass(input int k, output int open_cnt);
        open_cnt = 0;
        cycle(0, 1, 0, 0);
        if (barrera_abrir === 1'b1) open_cnt++;
        for (int i = 1; i <= k + HOLD + 20; i++) begin
            cycle(0, 0, (i == k), 0);
            if (barrera_abrir === 1'b1) open_cnt++;
        end
    endtask

    task automatic test_pass;
        int oc;
        cycle(1, 0, 0, 0);
        run_pass(5, oc);
        n_cmp++;
        if (oc != 5 + HOLD || ocupacion !== W'(1)) begin
            n_bad++; $display("FAIL pass5: open %0d occ=%0d expected %0d 1", oc, ocupacion, 5 + HOLD);
        end
        run_pass(TOUT, oc);
        n_cmp++;
        if (oc != TOUT + HOLD || ocupacion !== W'(2)) begin
            n_bad++; $display("FAIL pass_timeout_edge: open %0d occ=%0d expected %0d 2", oc, ocupacion, TOUT + HOLD);
        end
    endtask

    task automatic test_reset_mid;
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        n_cmp++;
        if (barrera_abrir !== 1'b1 || ocupacion !== W'(5)) begin
            n_bad++; $display("FAIL pre_reset: got bar=%b occ=%0d expected 1 5", barrera_abrir, ocupacion);
        end
        cycle(1, 1, 1, 0);
        n_cmp++;
        if (barrera_abrir !== 1'b0 || ocupacion !== W'(0) || vacio !== 1'b1) begin
            n_bad++; $display("FAIL reset_mid: got bar=%b occ=%0d vacio=%b expected 0 0 1", barrera_abrir, ocupacion, vacio);
        end
        cycle(0, 0, 0, 0);
        n_cmp++;
        if (barrera_abrir !== 1'b0) begin
            n_bad++; $display("FAIL reset_mid_closed: got bar=%b expected 0", barrera_abrir);
        end
    endtask

    task automatic test_random;
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
            n_cmp++;
            if ({barrera_abrir, ocupacion, lleno, vacio, rechazo, error_ovf, error_udf} !==
                {m_open, W'(m_occ), (m_occ == CAP), (m_occ == 0), m_rech, m_ovf, m_udf}) begin
                n_bad++;
                $display("FAIL random[%0d]: got bar=%b occ=%0d ll=%b va=%b rech=%b ovf=%b udf=%b expected %b %0d %b %b %b %b %b",
                         i, barrera_abrir, ocupacion, lleno, vacio, rechazo, error_ovf, error_udf,
                         m_open, m_occ, (m_occ == CAP), (m_occ == 0), m_rech, m_ovf, m_udf);
            end
`ifdef PARKING_TOTAL_EN
            n_cmp++;
            if (total_entradas !== 16'(m_total)) begin
                n_bad++; $display("FAIL random_total[%0d]: got %0d expected %0d", i, total_entradas, m_total);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_entrada_seq();
        test_fill_ovf();
        test_udf_simul();
        test_timeout();
        test_pass();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
